stack_seq: RTL and testbench

STACK_SEQ -- requirements
Module: stack_seq

---
 rtl/stack_seq_pkg.sv | 37 +++
 rtl/stack_seq_mem_wait_timer.sv | 26 ++
 rtl/stack_seq.sv | 152 +++++++++++++++
 tb/tb_stack_seq.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/stack_seq_pkg.sv
// Shared encodings for the stack sequencer: command ops, ALU operand selects,
// error codes and FSM states.
package stack_seq_pkg;

    typedef enum logic [1:0] {
        OP_PUSH = 2'b00,
        OP_POP  = 2'b01,
        OP_CALL = 2'b10,
        OP_RET  = 2'b11
    } op_e;

    localparam logic [2:0] SEL_SR_DR   = 3'b000;
    localparam logic [2:0] SEL_MEMDATA = 3'b101;
    localparam logic [2:0] SEL_SP_M1   = 3'b110;
    localparam logic [2:0] SEL_SP      = 3'b111;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'b00,
        ERR_OVERFLOW  = 2'b01,
        ERR_UNDERFLOW = 2'b10,
        ERR_TIMEOUT   = 2'b11
    } err_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_MEM  = 3'd2,
        ST_WB   = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // PUSH and CALL write to the stack; POP and RET read from it.
    function automatic logic is_write_op(input op_e op);
        return (op == OP_PUSH) || (op == OP_CALL);
    endfunction

endpackage

// File: rtl/stack_seq_mem_wait_timer.sv
// Memory wait counter: synchronous clear, count enable, terminal-count flag.
module mem_wait_timer #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [7:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 8'd0;
        end else if (i_clr) begin
            r_count <= 8'd0;
        end else if (i_en) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_tc = (r_count == TIMEOUT);

endmodule

// File: rtl/stack_seq.sv
// Stack push/pop/call/return micro-sequencer: drives ALU select, memory strobes
// and SP inc/dec for one command at a time, with boundary and timeout aborts.
module stack_seq
    import stack_seq_pkg::*;
#(
    parameter logic [15:0] SP_EMPTY = 16'h0400,
    parameter logic [15:0] SP_LIMIT = 16'h0300,
    parameter logic [7:0]  TIMEOUT  = 8'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    output logic        cmd_ready,
    input  logic [15:0] sp,
    input  logic        mem_ready,
    output logic [2:0]  alu_in_sel,
    output logic        addr_latch,
    output logic        mem_wr_en,
    output logic        mem_rd_en,
    output logic        wdata_sel,
    output logic        sp_dec,
    output logic        sp_inc,
    output logic        reg_wr_en,
    output logic        pc_load,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);

    state_e r_state;
    state_e w_state_nxt;
    op_e    r_op;
    op_e    w_op_nxt;
    err_e   r_err;
    err_e   w_err_nxt;

    logic   w_tmr_clr;
    logic   w_tmr_en;
    logic   w_tmr_tc;
    logic   w_wr_op;
    op_e    w_cmd_op;

    assign w_cmd_op = op_e'(cmd_op);
    assign w_wr_op  = is_write_op(r_op);

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_tmr_clr),
        .i_en  (w_tmr_en),
        .o_tc  (w_tmr_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_op    <= OP_PUSH;
            r_err   <= ERR_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Next state, latched op/outcome, and the combinational control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_err_nxt   = r_err;
        w_tmr_clr   = 1'b0;
        w_tmr_en    = 1'b0;
        cmd_ready   = 1'b0;
        alu_in_sel  = SEL_SR_DR;
        addr_latch  = 1'b0;
        mem_wr_en   = 1'b0;
        mem_rd_en   = 1'b0;
        wdata_sel   = 1'b0;
        sp_dec      = 1'b0;
        sp_inc      = 1'b0;
        reg_wr_en   = 1'b0;
        pc_load     = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        err_code    = ERR_NONE;

        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_op_nxt = w_cmd_op;
                    if (is_write_op(w_cmd_op) && (sp == SP_LIMIT)) begin
                        w_state_nxt = ST_DONE;
                        w_err_nxt   = ERR_OVERFLOW;
                    end else if (!is_write_op(w_cmd_op) && (sp == SP_EMPTY)) begin
                        w_state_nxt = ST_DONE;
                        w_err_nxt   = ERR_UNDERFLOW;
                    end else begin
                        w_state_nxt = ST_ADDR;
                        w_err_nxt   = ERR_NONE;
                    end
                end
            end

            ST_ADDR: begin
                alu_in_sel  = w_wr_op ? SEL_SP_M1 : SEL_SP;
                addr_latch  = 1'b1;
                w_tmr_clr   = 1'b1;
                w_state_nxt = ST_MEM;
            end

            // Strobes stay up for every MEM cycle; mem_ready beats the timeout.
            ST_MEM: begin
                mem_wr_en = w_wr_op;
                mem_rd_en = !w_wr_op;
                wdata_sel = w_wr_op && (r_op == OP_CALL);
                if (mem_ready) begin
                    sp_dec      = w_wr_op;
                    sp_inc      = !w_wr_op;
                    w_state_nxt = w_wr_op ? ST_DONE : ST_WB;
                end else if (w_tmr_tc) begin
                    w_err_nxt   = ERR_TIMEOUT;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end

            ST_WB: begin
                alu_in_sel  = SEL_MEMDATA;
                reg_wr_en   = (r_op == OP_POP);
                pc_load     = (r_op == OP_RET);
                w_state_nxt = ST_DONE;
            end

            ST_DONE: begin
                done        = 1'b1;
                err         = (r_err != ERR_NONE);
                err_code    = r_err;
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_stack_seq.sv
// Randomized self-checking bench for stack_seq: a transaction-level model expands
// each command into its expected per-cycle output vector sequence.
module tb_stack_seq;

    localparam logic [15:0] SP_EMPTY = 16'h0400;
    localparam logic [15:0] SP_LIMIT = 16'h0300;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic        cmd_ready;
    logic [15:0] sp;
    logic        mem_ready;
    logic [2:0]  alu_in_sel;
    logic        addr_latch, mem_wr_en, mem_rd_en, wdata_sel;
    logic        sp_dec, sp_inc, reg_wr_en, pc_load, done, err;
    logic [1:0]  err_code;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Vector layout: ready, sel[3], addr_latch, wr, rd, wdata_sel, sp_dec, sp_inc,
    // reg_wr, pc_load, done, err, err_code[2]
    logic [15:0] act;
    assign act = {cmd_ready, alu_in_sel, addr_latch, mem_wr_en, mem_rd_en, wdata_sel,
                  sp_dec, sp_inc, reg_wr_en, pc_load, done, err, err_code};

    logic [15:0] exp_q[$];
    int          rdy_q[$];   // 0/1 = required mem_ready, 2 = don't care (randomized)

    stack_seq #(
        .SP_EMPTY (SP_EMPTY),
        .SP_LIMIT (SP_LIMIT),
        .TIMEOUT  (8'd255)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .cmd_ready  (cmd_ready),
        .sp         (sp),
        .mem_ready  (mem_ready),
        .alu_in_sel (alu_in_sel),
        .addr_latch (addr_latch),
        .mem_wr_en  (mem_wr_en),
        .mem_rd_en  (mem_rd_en),
        .wdata_sel  (wdata_sel),
        .sp_dec     (sp_dec),
        .sp_inc     (sp_inc),
        .reg_wr_en  (reg_wr_en),
        .pc_load    (pc_load),
        .done       (done),
        .err        (err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    // Expand one command into expected vectors, starting with its accept cycle.
    // w = number of MEM cycles without mem_ready before it arrives (>=256: never).
    task automatic build(input logic [1:0] op, input logic [15:0] spv, input int w);
        logic        wr;
        logic [15:0] v;
        exp_q.delete();
        rdy_q.delete();
        exp_q.push_back(16'h8000); rdy_q.push_back(2);
        wr = (op == 2'b00) || (op == 2'b10);
        if (wr && spv == SP_LIMIT) begin
            exp_q.push_back(16'h000D); rdy_q.push_back(2);
            return;
        end
        if (!wr && spv == SP_EMPTY) begin
            exp_q.push_back(16'h000E); rdy_q.push_back(2);
            return;
        end
        exp_q.push_back(wr ? 16'h6800 : 16'h7800); rdy_q.push_back(2);
        for (int k = 0; k < 256; k++) begin
            v = wr ? (16'h0400 | ((op == 2'b10) ? 16'h0100 : 16'h0000)) : 16'h0200;
            if (k == w) begin
                exp_q.push_back(v | (wr ? 16'h0080 : 16'h0040)); rdy_q.push_back(1);
                break;
            end
            exp_q.push_back(v); rdy_q.push_back(0);
            if (k == 255) begin
                exp_q.push_back(16'h000F); rdy_q.push_back(2);
                return;
            end
        end
        if (!wr) begin
            exp_q.push_back((op == 2'b01) ? 16'h5020 : 16'h5010); rdy_q.push_back(2);
        end
        exp_q.push_back(16'h0008); rdy_q.push_back(2);
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, got, want);
        end
    endtask

    // Inputs already applied; compare at the falling edge, then advance one cycle.
    task automatic step(input logic [15:0] e, input string nm);
        @(negedge clk);
        check(nm, {16'h0, act}, {16'h0, e});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            cmd_valid = 1'b0;
            cmd_op    = 2'($urandom);
            sp        = 16'($urandom);
            mem_ready = 1'($urandom);
            step(16'h8000, "idle");
        end
    endtask

    // Runs the expanded command; busy_valid keeps cmd_valid high while busy.
    task automatic run_cmd(input logic [1:0] op, input logic [15:0] spv, input int w,
                           input bit busy_valid, input int stop_at);
        build(op, spv, w);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i == stop_at) return;
            if (i == 0) begin
                cmd_valid = 1'b1;
                cmd_op    = op;
                sp        = spv;
            end else begin
                cmd_valid = busy_valid ? 1'b1 : 1'($urandom);
                cmd_op    = 2'($urandom);
                sp        = busy_valid ? spv : 16'($urandom);
            end
            mem_ready = (rdy_q[i] == 2) ? 1'($urandom) : 1'(rdy_q[i]);
            step(exp_q[i], "cycle");
        end
    endtask

    function automatic logic [15:0] pick_sp();
        case ($urandom_range(0, 5))
            0:       return SP_LIMIT;
            1:       return SP_EMPTY;
            2:       return SP_LIMIT + 16'd1;
            3:       return SP_EMPTY - 16'd1;
            default: return 16'($urandom_range(16'h0301, 16'h03FF));
        endcase
    endfunction

    function automatic int pick_wait();
        int r;
        r = $urandom_range(0, 19);
        if (r < 14)  return $urandom_range(0, 4);
        if (r == 14) return 255;
        if (r == 15) return 256;
        return $urandom_range(5, 20);
    endfunction

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        sp        = SP_EMPTY;
        mem_ready = 1'b0;
        #2;
        check("reset_outputs", {16'h0, act}, 32'h0000_8000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Pin the model against hand-derived sequences.
        build(2'b00, 16'h0380, 0);
        check("model_push_len", exp_q.size(), 4);
        check("model_push_addr", {16'h0, exp_q[1]}, 32'h6800);
        check("model_push_mem", {16'h0, exp_q[2]}, 32'h0480);
        check("model_push_done", {16'h0, exp_q[3]}, 32'h0008);
        build(2'b11, 16'h03FF, 3);
        check("model_ret_len", exp_q.size(), 8);
        check("model_ret_last_mem", {16'h0, exp_q[5]}, 32'h0240);
        check("model_ret_wb", {16'h0, exp_q[6]}, 32'h5010);
        build(2'b10, 16'h0390, 256);
        check("model_tmo_len", exp_q.size(), 259);
        check("model_tmo_done", {16'h0, exp_q[258]}, 32'h000F);
        build(2'b01, SP_EMPTY, 0);
        check("model_unf_done", {16'h0, exp_q[1]}, 32'h000E);

        // Directed scenarios.
        idle_cycles(2);
        run_cmd(2'b00, 16'h0380, 0, 1'b0, -1);
        idle_cycles(1);
        run_cmd(2'b11, 16'h03FF, 3, 1'b0, -1);
        run_cmd(2'b00, SP_LIMIT, 0, 1'b0, -1);
        run_cmd(2'b01, SP_EMPTY, 0, 1'b0, -1);
        run_cmd(2'b10, 16'h0390, 256, 1'b0, -1);
        run_cmd(2'b10, 16'h0390, 255, 1'b0, -1);
        idle_cycles(1);

        // Reset during MEM of a POP aborts with no SP strobe and no done.
        run_cmd(2'b01, 16'h0390, 10, 1'b0, 4);
        mem_ready = 1'b1;
        rst_n     = 1'b0;
        #1;
        check("async_abort", {16'h0, act}, 32'h0000_8000);
        cmd_valid = 1'b0;
        step(16'h8000, "in_reset");
        rst_n = 1'b1;
        idle_cycles(1);
        run_cmd(2'b01, 16'h0390, 1, 1'b0, -1);

        // Back-to-back with cmd_valid held high.
        run_cmd(2'b00, 16'h0350, 0, 1'b1, -1);
        run_cmd(2'b01, 16'h0350, 0, 1'b1, -1);
        run_cmd(2'b10, 16'h0350, 2, 1'b1, -1);
        run_cmd(2'b11, SP_EMPTY, 0, 1'b1, -1);

        // Randomized commands with random gaps.
        for (int n = 0; n < 80; n++) begin
            idle_cycles($urandom_range(0, 2));
            run_cmd(2'($urandom), pick_sp(), pick_wait(), 1'($urandom), -1);
        end
        idle_cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
